// File: rtl/memory_dump_unit.sv
// memory_dump_unit: reads word_count consecutive RAM words starting at base_addr through a
// synchronous read port and streams them as {address, data} pairs on a valid/ready output.
//
// Optional build macro: DUMP_CHECKSUM_EN. When defined, a modulo-2^DATA_WIDTH sum of all
// dumped data words is appended as one extra stream word with out_addr = all-ones.
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   start                   one-cycle pulse that begins a dump (ignored while busy)
//   base_addr, word_count   dump range, sampled on start
//   mem_read, mem_addr      RAM read strobe and address
//   mem_read_data           RAM data, valid the cycle after mem_read
//   out_valid, out_ready    output stream handshake
//   out_addr, out_data      current stream word (FIFO head)
//   busy                    a dump is in progress
//   done                    one-cycle pulse after the last stream word is accepted
module memory_dump_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] FullC  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StRead, StSum, StDrain, StFinish} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] issued_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  inflight_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  logic                  push, pop, sum_push;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  // Checksum is only final once the last read has landed in the FIFO.
  assign sum_push = (state_q == StSum) && !inflight_q && (count_q != FullC);
`else
  assign sum_push = 1'b0;
`endif

  // Credit check: FIFO occupancy plus the read still in the RAM pipeline must leave a free slot.
  assign mem_read  = (state_q == StRead) &&
                     (({1'b0, count_q} + (CntW + 1)'(inflight_q)) < DepthC);
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign out_valid = (count_q != '0);
  assign out_addr  = fifo_addr[rd_ptr_q];
  assign out_data  = fifo_data[rd_ptr_q];

  assign push    = inflight_q | sum_push;
  assign pop     = out_valid & out_ready;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    push_addr = issued_addr_q;
    push_data = mem_read_data;
`ifdef DUMP_CHECKSUM_EN
    if (!inflight_q) begin
      push_addr = '1;
      push_data = sum_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      issued_addr_q <= '0;
      remaining_q   <= '0;
      inflight_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      inflight_q <= mem_read;
      if (mem_read) begin
        issued_addr_q <= addr_q;
        addr_q        <= addr_q + ADDR_WIDTH'(1);
        remaining_q   <= remaining_q - (ADDR_WIDTH + 1)'(1);
      end
`ifdef DUMP_CHECKSUM_EN
      if (inflight_q) sum_q <= sum_q + mem_read_data;
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
            if (word_count != '0) begin
              state_q <= StRead;
              busy_q  <= 1'b1;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              state_q <= StSum;
              busy_q  <= 1'b1;
`else
              state_q <= StFinish;
              done_q  <= 1'b1;
`endif
            end
          end
        end
        StRead: begin
          if (mem_read && (remaining_q == (ADDR_WIDTH + 1)'(1))) begin
`ifdef DUMP_CHECKSUM_EN
            state_q <= StSum;
`else
            state_q <= StDrain;
`endif
          end
        end
        StSum: begin
          if (sum_push) state_q <= StDrain;
        end
        StDrain: begin
          // Leave as the final pop happens so done lands in the following cycle.
          if (!inflight_q && (count_d == '0)) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr_q] <= push_addr;
        fifo_data[wr_ptr_q] <= push_data;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count_q == FullC)));

endmodule
